// File: rtl/cpu_pkg.sv
// Shared branch condition codes and branch-resolve FSM state encoding.
package cpu_pkg;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_AL = 3'b111;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation against the {Z,V,N} flags.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic flag_z, flag_v, flag_n;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_NE: cond_true = ~flag_z;
      COND_EQ: cond_true = flag_z;
      COND_GT: cond_true = ~flag_z & ~flag_n;
      COND_LT: cond_true = flag_n;
      COND_GE: cond_true = flag_z | (~flag_z & ~flag_n);
      COND_LE: cond_true = flag_z | flag_n;
      COND_OV: cond_true = flag_v;
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: direction/target check against fetch-time
// prediction, BHT/BTB update strobes, wrong-path squash FSM and statistics.
//
// state  | meaning
// RUN    | resolving branches in the decode slot
// SQUASH | wrong-path instruction in decode; suppress strobes until unstalled
module branch_resolve_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        is_br_reg,
  input  logic [2:0]  cond,
  input  logic [2:0]  flags,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic [1:0]  IF_ID_prediction,
  input  logic [15:0] IF_ID_predicted_target,
  input  logic [8:0]  branch_imm,
  input  logic [15:0] reg_target,
  output logic        actual_taken,
  output logic        wen_BHT,
  output logic        wen_BTB,
  output logic [15:0] branch_target,
  output logic [15:0] actual_target,
  output logic        update_PC,
  output logic        flush,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  bru_state_e  state_q, state_d;
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] mispredict_count_q, mispredict_count_d;

  logic        cond_true;
  logic        valid;
  logic        predicted_taken;
  logic        mispredict;
  logic [15:0] pc_plus2;

  branch_cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true)
  );

  assign pc_plus2        = IF_ID_PC_curr + 16'd2;
  assign branch_target   = is_br_reg ? reg_target
                         : pc_plus2 + {{6{branch_imm[8]}}, branch_imm, 1'b0};
  assign actual_taken    = is_branch & cond_true;
  assign actual_target   = actual_taken ? branch_target : pc_plus2;
  assign predicted_taken = IF_ID_prediction[1];
  assign mispredict      = (predicted_taken != actual_taken) |
                           (predicted_taken & actual_taken &
                            (IF_ID_predicted_target != branch_target));

  assign valid     = is_branch & ~stall & (state_q == RUN);
  assign wen_BHT   = valid;
  assign wen_BTB   = valid & actual_taken;
  assign update_PC = valid & mispredict;
  assign flush     = (state_q == SQUASH);

  always_comb begin
    state_d            = state_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    case (state_q)
      RUN:     if (update_PC) state_d = SQUASH;
      SQUASH:  if (!stall)    state_d = RUN;
      default: state_d = RUN;
    endcase
    if (valid && branch_count_q != CNT_MAX)
      branch_count_d = branch_count_q + 16'd1;
    if (update_PC && mispredict_count_q != CNT_MAX)
      mispredict_count_d = mispredict_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= RUN;
      branch_count_q     <= 16'd0;
      mispredict_count_q <= 16'd0;
    end else begin
      state_q            <= state_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
